axi_rd_arb: RTL and testbench



---
 rtl/axi_rd_arb.sv | 199 +++++++++++++++++++
 tb/tb_axi_rd_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: read-side AXI master shared by the instruction and data caches.
// One outstanding read at a time: arbitrate in IDLE, issue AR, gather R beats
// into a line buffer, then pulse the owner's ret_valid with the assembled line.
module axi_rd_arb #(
  parameter int BYTES_PER_LINE = 16,
  parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
  parameter int LINE_WIDTH     = WORDS_PER_LINE * 32
) (
  input  logic                  clk,
  input  logic                  reset,

  // instruction cache requester
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  input  logic                  i_burst,
  input  logic [1:0]            i_size,
  output logic                  i_rdy,
  output logic                  i_ret_valid,

  // data cache requester
  input  logic                  d_req,
  input  logic [31:0]           d_addr,
  input  logic                  d_burst,
  input  logic [1:0]            d_size,
  output logic                  d_rdy,
  output logic                  d_ret_valid,

  output logic [LINE_WIDTH-1:0] ret_data,

  // write-buffer coordination
  input  logic                  wr_idle,
  output logic                  read_unfinish,

  // AXI AR channel
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,

  // AXI R channel
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int unsigned NW    = WORDS_PER_LINE;
  localparam int unsigned PTR_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_RET
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  // 1 = data cache owned the most recent completed read
  logic                    r_last_d;
  // 1 = current transaction belongs to the data cache
  logic                    r_owner_d;
  logic [31:0]             r_addr;
  logic                    r_burst;
  logic [1:0]              r_size;
  logic [PTR_W-1:0]        r_ptr;
  logic [LINE_WIDTH-1:0]   r_line;

  logic                    w_idle;
  logic                    w_i_elig;
  logic                    w_d_elig;
  logic                    w_grant_i;
  logic                    w_grant_d;
  logic                    w_grant;
  logic                    w_ar_hs;
  logic                    w_r_hs;

  // ID and response code are not needed with a single outstanding read
  logic                    w_unused_axi;
  assign w_unused_axi = ^{rid, rresp};

  assign w_idle   = (r_state == S_IDLE);
  assign w_i_elig = i_req;
  // data reads wait for the write buffer to drain so they never pass a write
  assign w_d_elig = d_req & wr_idle;

  // round-robin on a tie: whoever did not win last time goes first
  assign w_grant_i = !reset && w_idle && w_i_elig && (!w_d_elig || r_last_d);
  assign w_grant_d = !reset && w_idle && w_d_elig && (!w_i_elig || !r_last_d);
  assign w_grant   = w_grant_i | w_grant_d;

  assign i_rdy = w_grant_i;
  assign d_rdy = w_grant_d;

  assign w_ar_hs = arvalid & arready;
  assign w_r_hs  = rready & rvalid;

  // AR payload is built from the request latched at grant time
  assign arid     = r_owner_d ? 4'd1 : 4'd0;
  assign araddr   = r_addr;
  assign arlen    = r_burst ? 8'(WORDS_PER_LINE - 1) : 8'd0;
  assign arsize   = r_burst ? 3'd2 : {1'b0, r_size};
  assign arburst  = r_burst ? 2'b01 : 2'b00;
  assign arlock   = '0;
  assign arcache  = '0;
  assign arprot   = '0;

  assign ret_data = r_line;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    w_next        = r_state;
    arvalid       = 1'b0;
    rready        = 1'b0;
    i_ret_valid   = 1'b0;
    d_ret_valid   = 1'b0;
    read_unfinish = 1'b1;
    case (r_state)
      S_IDLE: begin
        read_unfinish = 1'b0;
        if (w_grant) begin
          w_next = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_next = S_R;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          w_next = S_RET;
        end
      end
      S_RET: begin
        i_ret_valid = !r_owner_d;
        d_ret_valid = r_owner_d;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // round-robin history, updated as each read is returned
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_RET) begin
      r_last_d <= r_owner_d;
    end
  end

  // capture the winning request
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_owner_d <= w_grant_d;
      r_addr    <= w_grant_d ? d_addr  : i_addr;
      r_burst   <= w_grant_d ? d_burst : i_burst;
      r_size    <= w_grant_d ? d_size  : i_size;
    end
  end

  // beat pointer and line buffer fill
  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_ptr <= '0;
    end else if (w_r_hs) begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (r_ptr == PTR_W'(w)) begin
          r_line[w*32 +: 32] <= rdata;
        end
      end
      r_ptr <= r_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: directed vector table, reset corner cases and randomized
// transactions against a behavioural arbitration / line-buffer model.
module tb_axi_rd_arb;

  localparam int WPL = 4;
  localparam int LW  = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_burst, i_rdy, i_ret_valid;
  logic [31:0]   i_addr;
  logic [1:0]    i_size;
  logic          d_req, d_burst, d_rdy, d_ret_valid;
  logic [31:0]   d_addr;
  logic [1:0]    d_size;
  logic [LW-1:0] ret_data;
  logic          wr_idle, read_unfinish;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst, arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid, arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;

  axi_rd_arb #(.BYTES_PER_LINE(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_burst(i_burst), .i_size(i_size),
    .i_rdy(i_rdy), .i_ret_valid(i_ret_valid),
    .d_req(d_req), .d_addr(d_addr), .d_burst(d_burst), .d_size(d_size),
    .d_rdy(d_rdy), .d_ret_valid(d_ret_valid),
    .ret_data(ret_data), .wr_idle(wr_idle), .read_unfinish(read_unfinish),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  // exp_g: 0 = I granted, 1 = D granted, 2 = nobody
  typedef struct packed {
    logic        ireq;
    logic        dreq;
    logic        wri;
    logic        iburst;
    logic        dburst;
    logic [1:0]  isize;
    logic [1:0]  dsize;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [3:0]  stall;
    logic [3:0]  gap;
    logic        fixed;
    logic [1:0]  exp_g;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_line [WPL];
  logic        ref_last;
  vec_t        vecs [11];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // arbitration rule: eligibility, then round-robin on a tie
  function automatic logic [1:0] model_grant(input logic ir, input logic dr, input logic wi,
                                             input logic last_d);
    logic ie, de;
    ie = ir;
    de = dr & wi;
    if (ie && de) return last_d ? 2'd0 : 2'd1;
    if (ie) return 2'd0;
    if (de) return 2'd1;
    return 2'd2;
  endfunction

  // Entered just after a negedge with the DUT idle; leaves just after the
  // negedge of the first idle cycle following the return (or the idle cycle).
  task automatic run_txn(input vec_t v);
    logic          own, b;
    logic [31:0]   a, dat;
    logic [1:0]    sz;
    int            n;
    logic [LW-1:0] exp_line;
    chk("idle_unfinish", 128'(read_unfinish), 128'(0));
    i_req = v.ireq; d_req = v.dreq; wr_idle = v.wri;
    i_addr = v.iaddr; d_addr = v.daddr;
    i_burst = v.iburst; d_burst = v.dburst;
    i_size = v.isize; d_size = v.dsize;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("i_rdy", 128'(i_rdy), 128'(v.exp_g == 2'd0));
    chk("d_rdy", 128'(d_rdy), 128'(v.exp_g == 2'd1));
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    if (v.exp_g == 2'd2) return;
    own = (v.exp_g == 2'd1);
    a   = own ? v.daddr  : v.iaddr;
    b   = own ? v.dburst : v.iburst;
    sz  = own ? v.dsize  : v.isize;
    n   = b ? WPL : 1;
    for (int k = 0; k <= int'(v.stall); k++) begin
      arready = (k == int'(v.stall));
      #1;
      chk("arvalid", 128'(arvalid), 128'(1));
      chk("araddr", 128'(araddr), 128'(a));
      chk("arlen", 128'(arlen), 128'(b ? 8'd3 : 8'd0));
      chk("arsize", 128'(arsize), 128'(b ? 3'd2 : {1'b0, sz}));
      chk("arburst", 128'(arburst), 128'(b ? 2'b01 : 2'b00));
      chk("arid", 128'(arid), 128'(own ? 4'd1 : 4'd0));
      chk("ar_misc", 128'({arlock, arcache, arprot}), 128'(0));
      chk("ar_rready", 128'(rready), 128'(0));
      chk("ar_unfinish", 128'(read_unfinish), 128'(1));
      @(negedge clk);
    end
    arready = 1'b0;
    for (int bt = 0; bt < n; bt++) begin
      for (int gp = 0; gp < int'(v.gap); gp++) begin
        rvalid = 1'b0;
        #1;
        chk("gap_rready", 128'(rready), 128'(1));
        chk("gap_arvalid", 128'(arvalid), 128'(0));
        chk("gap_ret", 128'({i_ret_valid, d_ret_valid}), 128'(0));
        chk("gap_unfinish", 128'(read_unfinish), 128'(1));
        @(negedge clk);
      end
      dat = v.fixed ? 32'(17 * (bt + 1)) : $urandom;
      rvalid = 1'b1; rdata = dat; rlast = (bt == n - 1);
      ref_line[bt] = dat;
      #1;
      chk("beat_rready", 128'(rready), 128'(1));
      chk("beat_ret", 128'({i_ret_valid, d_ret_valid}), 128'(0));
      chk("beat_unfinish", 128'(read_unfinish), 128'(1));
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("i_ret_valid", 128'(i_ret_valid), 128'(!own));
    chk("d_ret_valid", 128'(d_ret_valid), 128'(own));
    chk("ret_unfinish", 128'(read_unfinish), 128'(1));
    chk("ret_rready", 128'(rready), 128'(0));
    for (int w = 0; w < WPL; w++) exp_line[w*32 +: 32] = ref_line[w];
    chk("ret_data", 128'(ret_data), 128'(exp_line));
    ref_last = own;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic ir, input logic dr, input logic wi,
                              input logic ib, input logic db, input logic [1:0] is,
                              input logic [1:0] ds, input logic [31:0] ia,
                              input logic [31:0] da, input int st, input int gp,
                              input logic fx, input logic [1:0] g);
    vec_t v;
    v.ireq = ir; v.dreq = dr; v.wri = wi; v.iburst = ib; v.dburst = db;
    v.isize = is; v.dsize = ds; v.iaddr = ia; v.daddr = da;
    v.stall = 4'(st); v.gap = 4'(gp); v.fixed = fx; v.exp_g = g;
    return v;
  endfunction

  initial begin
    vec_t v;
    //             ir dr wi ib db is     ds     iaddr         daddr         st gp fx g
    vecs[0]  = mk(1, 0, 1, 1, 0, 2'd2, 2'd0, 32'h1C000040, 32'h0,        0, 0, 1, 2'd0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 2'd0, 2'd1, 32'h0,        32'h80000002, 0, 0, 0, 2'd1);
    vecs[2]  = mk(1, 1, 1, 1, 1, 2'd2, 2'd2, 32'h1C000100, 32'h80000200, 0, 0, 0, 2'd0);
    vecs[3]  = mk(1, 1, 1, 1, 1, 2'd2, 2'd2, 32'h1C000110, 32'h80000210, 0, 0, 0, 2'd1);
    vecs[4]  = mk(1, 1, 1, 1, 1, 2'd2, 2'd2, 32'h1C000120, 32'h80000220, 0, 1, 0, 2'd0);
    vecs[5]  = mk(1, 1, 0, 1, 1, 2'd2, 2'd2, 32'h1C000130, 32'h80000230, 0, 0, 0, 2'd0);
    vecs[6]  = mk(0, 1, 0, 0, 1, 2'd0, 2'd2, 32'h0,        32'h80000240, 0, 0, 0, 2'd2);
    vecs[7]  = mk(1, 1, 1, 1, 1, 2'd2, 2'd2, 32'h1C000140, 32'h80000240, 0, 0, 0, 2'd1);
    vecs[8]  = mk(1, 0, 1, 1, 0, 2'd2, 2'd0, 32'h1C000200, 32'h0,        3, 2, 0, 2'd0);
    vecs[9]  = mk(0, 1, 1, 0, 1, 2'd0, 2'd2, 32'h0,        32'h80000300, 1, 1, 0, 2'd1);
    vecs[10] = mk(1, 0, 1, 0, 0, 2'd0, 2'd0, 32'h1C000303, 32'h0,        0, 0, 0, 2'd0);

    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; wr_idle = 1'b1;
    i_addr = '0; d_addr = '0; i_burst = 1'b0; d_burst = 1'b0; i_size = '0; d_size = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
    ref_last = 1'b0;
    for (int w = 0; w < WPL; w++) ref_line[w] = '0;
    repeat (2) @(negedge clk);
    chk("rst_valids", 128'({arvalid, rready, i_rdy, d_rdy, i_ret_valid, d_ret_valid}), 128'(0));
    chk("rst_unfinish", 128'(read_unfinish), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);
    chk("first_line", 128'({ref_line[3], ref_line[2], ref_line[1], ref_line[0]}),
        128'({32'h0, 32'h0, 32'h0, 32'h0}) | 128'(ret_data) ^ 128'(ret_data) |
        {96'h0, ref_line[0]} | {64'h0, ref_line[1], 32'h0} | {32'h0, ref_line[2], 64'h0} |
        {ref_line[3], 96'h0});

    // reset in R after two beats: abandon the read, then recover
    i_req = 1'b1; i_burst = 1'b1; i_addr = 32'h1C000400;
    #1 chk("mr_i_rdy", 128'(i_rdy), 128'(1));
    @(negedge clk);
    i_req = 1'b0; arready = 1'b1;
    #1 chk("mr_arvalid", 128'(arvalid), 128'(1));
    @(negedge clk);
    arready = 1'b0;
    for (int bt = 0; bt < 2; bt++) begin
      rvalid = 1'b1; rdata = $urandom; rlast = 1'b0;
      #1 chk("mr_rready", 128'(rready), 128'(1));
      @(negedge clk);
    end
    rvalid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_rready0", 128'(rready), 128'(0));
    chk("mr_unfinish0", 128'(read_unfinish), 128'(0));
    chk("mr_ret0", 128'({i_ret_valid, d_ret_valid, arvalid}), 128'(0));
    @(negedge clk);
    chk("mr_ret1", 128'({i_ret_valid, d_ret_valid, read_unfinish}), 128'(0));
    ref_last = 1'b0;
    run_txn(mk(1, 0, 1, 1, 0, 2'd2, 2'd0, 32'h1C000500, 32'h0, 0, 0, 0, 2'd0));
    ref_last = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_txn(mk(1, 1, 1, 1, 1, 2'd2, 2'd2, 32'h1C000600, 32'h80000600, 0, 0, 0, 2'd1));

    // randomized transactions checked against the arbitration model
    for (int t = 0; t < 40; t++) begin
      v.ireq   = 1'($urandom_range(0, 1));
      v.dreq   = 1'($urandom_range(0, 1));
      v.wri    = 1'($urandom_range(0, 1));
      v.iburst = 1'($urandom_range(0, 1));
      v.dburst = 1'($urandom_range(0, 1));
      v.isize  = 2'($urandom_range(0, 2));
      v.dsize  = 2'($urandom_range(0, 2));
      v.iaddr  = $urandom;
      v.daddr  = $urandom;
      v.stall  = 4'($urandom_range(0, 3));
      v.gap    = 4'($urandom_range(0, 2));
      v.fixed  = 1'b0;
      v.exp_g  = model_grant(v.ireq, v.dreq, v.wri, ref_last);
      run_txn(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
